// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle between the initiator and a responder.
// Channels: AW (address write), W (write data), B (write response),
//           AR (address read), R (read data/response).
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where VALID and READY are both 1; the source holds VALID and payload stable
// until that edge and never withdraws VALID before it.
// Modports:
//   master - drives AW/W/AR payload + VALID and B_READY/R_READY
//   slave  - drives AW/W/AR READY and B/R payload + VALID
interface axi4lite_master_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
   logic                      AW_VALID;
   logic                      AW_READY;
   logic [AXI_DATA_WIDTH-1:0] W_DATA;
   logic                      W_VALID;
   logic                      W_READY;
   logic [1:0]                B_RESP;
   logic                      B_VALID;
   logic                      B_READY;
   logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
   logic                      AR_VALID;
   logic                      AR_READY;
   logic [AXI_DATA_WIDTH-1:0] R_DATA;
   logic [1:0]                R_RESP;
   logic                      R_VALID;
   logic                      R_READY;

   modport master (
      output AW_ADDR, AW_VALID, W_DATA, W_VALID, B_READY,
      output AR_ADDR, AR_VALID, R_READY,
      input  AW_READY, W_READY, B_RESP, B_VALID,
      input  AR_READY, R_DATA, R_RESP, R_VALID
   );

   modport slave (
      input  AW_ADDR, AW_VALID, W_DATA, W_VALID, B_READY,
      input  AR_ADDR, AR_VALID, R_READY,
      output AW_READY, W_READY, B_RESP, B_VALID,
      output AR_READY, R_DATA, R_RESP, R_VALID
   );
endinterface

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: turns one local command at a time into a single
// AXI4-Lite write or read and returns the captured response.
// Ports:
//   A_CLK, A_RST          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_write, rsp_resp, rsp_rdata
//   timeout_err           sticky watchdog flag (responder stalled)
//   dbg_state             current FSM state for observation
//   axi                   AXI4-Lite master modport
// All AXI outputs come from flops or are decoded from the state register,
// so there is no combinational path from any input to any output.
module axi4lite_master #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      A_CLK,
   input  logic                      A_RST,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [1:0]                rsp_resp,
   output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      timeout_err,
   output logic [2:0]                dbg_state,
   axi4lite_master_if.master         axi
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RSP     = 3'd5;

   // With TIMEOUT_CYCLES == 0 the limit is 0, the counter never moves and
   // the flag never sets, which disables the watchdog.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [2:0]                state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic                      aw_valid_q;
   logic                      w_valid_q;
   logic                      ar_valid_q;
   logic                      aw_done;
   logic                      w_done;
   logic                      rsp_write_q;
   logic [1:0]                rsp_resp_q;
   logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q;
   logic [CNT_W-1:0]          wd_cnt;
   logic                      timeout_q;

   logic cmd_hs;
   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic aw_fin;
   logic w_fin;
   logic busy;

   assign cmd_hs = cmd_valid && (state == IDLE);
   assign aw_hs  = aw_valid_q && axi.AW_READY;
   assign w_hs   = w_valid_q && axi.W_READY;
   assign ar_hs  = ar_valid_q && axi.AR_READY;
   // A channel is finished if it completed earlier or completes this edge.
   assign aw_fin = aw_done || aw_hs;
   assign w_fin  = w_done || w_hs;
   assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_ADDR) || (state == RD_DATA);

   always_ff @(posedge A_CLK) begin
      if (A_RST) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_resp_q  <= 2'b00;
         rsp_rdata_q <= '0;
         wd_cnt      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_write ? cmd_wdata : '0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= cmd_write ? WR_REQ : RD_ADDR;
               end
            end
            WR_REQ: begin
               // VALIDs rise on the first WR_REQ cycle and each drops for
               // good once its own channel has handshaken.
               aw_done    <= aw_fin;
               w_done     <= w_fin;
               aw_valid_q <= !aw_fin;
               w_valid_q  <= !w_fin;
               if (aw_fin && w_fin) state <= WR_RESP;
            end
            WR_RESP: begin
               if (axi.B_VALID) begin
                  rsp_resp_q  <= axi.B_RESP;
                  rsp_write_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  state       <= RSP;
               end
            end
            RD_ADDR: begin
               ar_valid_q <= !ar_hs;
               if (ar_hs) state <= RD_DATA;
            end
            RD_DATA: begin
               if (axi.R_VALID) begin
                  rsp_resp_q  <= axi.R_RESP;
                  rsp_rdata_q <= axi.R_DATA;
                  rsp_write_q <= 1'b0;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  addr_q      <= '0;
                  wdata_q     <= '0;
                  rsp_write_q <= 1'b0;
                  rsp_resp_q  <= 2'b00;
                  rsp_rdata_q <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Watchdog: flags a stall but never aborts the transaction.
         if (cmd_hs) begin
            wd_cnt <= '0;
         end else if (busy && (wd_cnt != CNT_MAX)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if ((wd_cnt + 1'b1) == CNT_MAX) timeout_q <= 1'b1;
         end
      end
   end

   assign cmd_ready    = (state == IDLE);
   assign rsp_valid    = (state == RSP);
   assign rsp_write    = rsp_write_q;
   assign rsp_resp     = rsp_resp_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign timeout_err  = timeout_q;
   assign dbg_state    = state;

   assign axi.AW_ADDR  = addr_q;
   assign axi.AR_ADDR  = addr_q;
   assign axi.W_DATA   = wdata_q;
   assign axi.AW_VALID = aw_valid_q;
   assign axi.W_VALID  = w_valid_q;
   assign axi.AR_VALID = ar_valid_q;
   assign axi.B_READY  = (state == WR_RESP);
   assign axi.R_READY  = (state == RD_DATA);

endmodule
